// File: rtl/pattern_playback_sequencer_pkg.sv
`default_nettype none
// pattern_playback_sequencer_pkg: playback state encoding and LED one-hot decode.
// Rev 1.0
package pattern_playback_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    SHOW      = 3'd3,
    GAP       = 3'd4,
    FINISH    = 3'd5
  } pps_state_e;

  function automatic logic [3:0] led_decode(input logic [1:0] elem);
    return 4'b0001 << elem;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_playback_sequencer_countdown_timer.sv
`default_nettype none
// countdown_timer: loadable down-counter; expired is high while the count is 1.
// Rev 1.0
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Expiry at 1 gives exactly load_val_i cycles between a load and the next state.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/pattern_playback_sequencer.sv
`default_nettype none
// pattern_playback_sequencer: plays a stored pattern on four one-hot LEDs.
// Rev 1.0
module pattern_playback_sequencer
  import pattern_playback_sequencer_pkg::*;
#(
  parameter int ON_CLKS  = 12500000,
  parameter int GAP_CLKS = 6250000,
  parameter int MAX_LEN  = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic                         i_Start,
  input  logic                         i_Abort,
  input  logic [$clog2(MAX_LEN+1)-1:0] i_Length,
  output logic [ADDR_W-1:0]            o_Rd_Addr,
  input  logic [1:0]                   i_Rd_Data,
  output logic [3:0]                   o_LED,
  output logic                         o_Busy,
  output logic                         o_Done
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int TMR_W = $clog2(((ON_CLKS > GAP_CLKS) ? ON_CLKS : GAP_CLKS) + 1);
  localparam int CMP_W = ((ADDR_W + 1) > LEN_W) ? (ADDR_W + 1) : LEN_W;

  pps_state_e        state_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        led_q;
  logic              busy_q;
  logic              done_q;

  logic [LEN_W-1:0]  w_len_clamped;
  logic              w_last;
  logic              w_expired;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;

  assign w_len_clamped = (i_Length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_Length;
  assign w_last        = (CMP_W'(idx_q) + CMP_W'(1)) >= CMP_W'(len_q);
  assign w_tmr_load    = (state_q == WAIT_DATA) || ((state_q == SHOW) && w_expired);
  assign w_tmr_val     = (state_q == WAIT_DATA) ? TMR_W'(ON_CLKS) : TMR_W'(GAP_CLKS);

  countdown_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i      (i_Clk),
    .rst_ni     (i_Rst_L),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .expired_o  (w_expired)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      led_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_Abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        led_q   <= 4'b0000;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_Start && !i_Abort) begin
              len_q <= w_len_clamped;
              idx_q <= '0;
              if (w_len_clamped == '0) begin
                state_q <= FINISH;
                done_q  <= 1'b1;
              end else begin
                state_q <= FETCH;
                addr_q  <= '0;
                busy_q  <= 1'b1;
              end
            end
          end
          FETCH: begin
            state_q <= WAIT_DATA;
          end
          WAIT_DATA: begin
            led_q   <= led_decode(i_Rd_Data);
            state_q <= SHOW;
          end
          SHOW: begin
            if (w_expired) begin
              led_q   <= 4'b0000;
              state_q <= GAP;
            end
          end
          GAP: begin
            if (w_expired) begin
              if (!w_last) begin
                idx_q   <= idx_q + ADDR_W'(1);
                addr_q  <= idx_q + ADDR_W'(1);
                state_q <= FETCH;
              end else begin
                state_q <= FINISH;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          FINISH: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_Rd_Addr = addr_q;
  assign o_LED     = led_q;
  assign o_Busy    = busy_q;
  assign o_Done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_playback_sequencer.sv
`default_nettype none
// tb_pattern_playback_sequencer: directed cycle-accurate checks with ON=4, GAP=2.
// Rev 1.0
module tb_pattern_playback_sequencer;

  localparam int ON  = 4;
  localparam int GAP = 2;
  localparam int P   = ON + GAP + 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [4:0] length;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic       busy;
  logic       done;

  logic [1:0] mem [16];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  pattern_playback_sequencer #(
    .ON_CLKS  (ON),
    .GAP_CLKS (GAP),
    .MAX_LEN  (16),
    .ADDR_W   (4)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Start   (start),
    .i_Abort   (abort),
    .i_Length  (length),
    .o_Rd_Addr (rd_addr),
    .i_Rd_Data (rd_data),
    .o_LED     (led),
    .o_Busy    (busy),
    .o_Done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern memory with one-cycle read latency.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " led"}, 32'(led), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " done"}, 32'(done), 32'h0);
  endtask

  // Starts in the current cycle (N) and checks every cycle through done+1.
  task automatic play(input int len, input int L, input bit glitch);
    length = 5'(len);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 1; k <= L * P + 1; k++) begin
      int         e;
      int         ph;
      logic [3:0] exp_led;
      e       = (k - 1) / P;
      ph      = (k - 1) % P;
      exp_led = 4'b0000;
      if ((k <= L * P) && (ph >= 2) && (ph < 2 + ON)) exp_led = 4'b0001 << mem[e];
      chk($sformatf("led N+%0d", k), 32'(led), 32'(exp_led));
      chk($sformatf("busy N+%0d", k), 32'(busy), 32'(k <= L * P));
      chk($sformatf("done N+%0d", k), 32'(done), 32'(k == L * P + 1));
      if ((k <= L * P) && (ph == 0)) chk($sformatf("addr N+%0d", k), 32'(rd_addr), 32'(e));
      start = glitch && ((k == 5) || (k == L * P + 1));
      tick();
    end
    start = 1'b0;
    chk_idle("after done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    length = 5'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    mem[0] = 2'd0;
    mem[1] = 2'd3;
    mem[2] = 2'd1;

    repeat (2) tick();
    chk_idle("in reset");
    chk("in reset addr", 32'(rd_addr), 32'h0);
    rst_n = 1'b1;
    tick();
    chk_idle("post reset");

    // Length 3, pattern {0,3,1}.
    play(3, 3, 1'b0);

    // Length 0: done next cycle, no read issued.
    play(0, 0, 1'b0);
    chk("len0 addr held", 32'(rd_addr), 32'h2);

    // Length 20 clamps to 16 elements.
    for (int i = 0; i < 16; i++) mem[i] = 2'(i ^ (i >> 2));
    play(20, 16, 1'b0);
    chk("clamp last addr", 32'(rd_addr), 32'hf);
    mem[0] = 2'd0;
    mem[1] = 2'd3;
    mem[2] = 2'd1;

    // Starts mid-playback and in the done cycle are ignored; done+1 is accepted.
    play(3, 3, 1'b1);
    play(3, 3, 1'b0);

    // Abort during the second element, then restart from address 0.
    length = 5'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (11) tick();
    chk("abort pre led", 32'(led), 32'h8);
    chk("abort pre busy", 32'(busy), 32'h1);
    chk("abort pre addr", 32'(rd_addr), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort N+13");
    tick();
    chk_idle("abort N+14");
    chk("abort addr held", 32'(rd_addr), 32'h1);
    play(3, 3, 1'b0);

    // Abort wins over a simultaneous start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("start+abort");
    tick();
    chk_idle("start+abort +1");

    // Asynchronous reset in the middle of SHOW.
    length = 5'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (11) tick();
    chk("rst pre led", 32'(led), 32'h8);
    chk("rst pre addr", 32'(rd_addr), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async rst");
    chk("async rst addr", 32'(rd_addr), 32'h0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post rst busy %0d", i), 32'(busy), 32'h0);
      chk($sformatf("post rst led %0d", i), 32'(led), 32'h0);
    end
    play(3, 3, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
